// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryptor that runs one full round per clock.
// A job is accepted in IDLE, runs NR rounds in RUN with the key schedule expanded
// on the fly, and is held in DONE until the consumer takes the ciphertext.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e       fsm_q;
  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as the multiplicative inverse (a^254, which maps 0 to 0)
  // followed by the affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = gf_mul(a, a);
    inv = p;
    for (int i = 0; i < 6; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the AES-128 key schedule: words w0..w3 are the key columns.
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // SubBytes + ShiftRows fused (row r rotates left by r), then MixColumns unless
  // this is the last round, then AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] nk,
                                             input logic last);
    logic [127:0] sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-8*(4*c)   -: 8];
      a1 = sr[127-8*(4*c+1) -: 8];
      a2 = sr[127-8*(4*c+2) -: 8];
      a3 = sr[127-8*(4*c+3) -: 8];
      mc[127-8*(4*c)   -: 8] = xtime(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
      mc[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ gf_mul(a2, 8'h03) ^ a3;
      mc[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ gf_mul(a3, 8'h03);
      mc[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3);
    end
    return (last ? sr : mc) ^ nk;
  endfunction

  // Next round key and next state, computed from the current registers.
  // NOTE: every variable here is assigned on every pass, so no latch is inferred.
  always_comb begin
    rk_d   = key_expand(rk_q, rcon(rnd_q));
    data_d = aes_round(data_q, rk_d, rnd_q == NR_L);
  end

  // Job control FSM with the state, round-key and round-counter registers.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      data_q <= '0;
      rk_q   <= '0;
      rnd_q  <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= plaintext ^ key;
            rk_q   <= key;
            rnd_q  <= 4'd1;
            fsm_q  <= RUN;
          end
        end
        RUN: begin
          data_q <= data_d;
          rk_q   <= rk_d;
          if (rnd_q == NR_L) fsm_q <= DONE;
          else               rnd_q <= rnd_q + 4'd1;
        end
        DONE: begin
          if (out_ready) begin
            fsm_q <= IDLE;
            rnd_q <= '0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from flops, so they never depend on inputs.
  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q != IDLE);
  assign round      = in_ready ? 4'd0 : rnd_q;
  assign ciphertext = data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: known-answer vectors through a scoreboard, plus sequences for
// backpressure, busy-ignore, reset abort and back-to-back jobs.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, key, ciphertext;
  logic [3:0]   round;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  logic ov_prev = 1'b0;
  logic [127:0] sb[$];
  logic [127:0] exp_ct;
  vec_t vecs[4];

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .round(round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total = total + 1;
    bad = bad + 1;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor at the falling edge: records accepts, checks latency on out_valid
  // rise, and pops the scoreboard on each completed output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_edge = edge_cnt + 1;
      if (out_valid && !ov_prev) check("latency", 128'(edge_cnt - acc_edge), 128'(NR));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          exp_ct = sb.pop_front();
          check("ciphertext", ciphertext, exp_ct);
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_in_ready"},  128'(in_ready),  128'd1);
    check({nm, "_out_valid"}, 128'(out_valid), 128'd0);
    check({nm, "_busy"},      128'(busy),      128'd0);
    check({nm, "_round"},     128'(round),     128'd0);
  endtask

  task automatic drive_job(input vec_t v, input bit hold);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1;
      else step();
    end
    if (!ok) fail_now("wait_in_ready");
    plaintext = v.pt;
    key       = v.key;
    in_valid  = 1'b1;
    sb.push_back(v.ct);
    step();
    if (!hold) in_valid = 1'b0;
    check("accept_busy",     128'(busy),     128'd1);
    check("accept_in_ready", 128'(in_ready), 128'd0);
    check("accept_round",    128'(round),    128'd1);
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_valid) ok = 1;
      else step();
    end
    if (!ok) fail_now("wait_out_valid");
  endtask

  task automatic wait_round(input logic [3:0] r);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (round == r) ok = 1;
      else step();
    end
    if (!ok) fail_now("wait_round");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[3] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hf5d3d58503b9699de785895a96fdbaaf};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    plaintext = '0; key = '0;

    // Reset values before any clock edge, then across edges.
    #2;
    check_idle("rst_noclk");
    check("rst_noclk_ct", ciphertext, 128'd0);
    step();
    step();
    check_idle("rst_clk");
    check("rst_clk_ct", ciphertext, 128'd0);

    // Release reset and accept on the very next edge; then all vectors.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_job(vecs[i], 1'b0);
      wait_valid();
      step();
      check_idle("after_job");
    end

    // Backpressure: hold out_ready low for 5 cycles in DONE.
    out_ready = 1'b0;
    drive_job(vecs[0], 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ct",        ciphertext,      vecs[0].ct);
      check("bp_in_ready",  128'(in_ready),  128'd0);
      check("bp_round",     128'(round),     128'(NR));
      step();
    end
    out_ready = 1'b1;
    step();
    check_idle("bp_release");

    // Busy ignore: stray in_valid pulses with other data at rounds 3 and 7.
    drive_job(vecs[0], 1'b0);
    wait_round(4'd3);
    plaintext = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ign3_round", 128'(round), 128'd4);
    wait_round(4'd7);
    key = 128'h0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ign7_round", 128'(round), 128'd8);
    wait_valid();
    step();
    check_idle("ign_done");

    // Reset abort at round 5, then a clean App. C.1 job.
    drive_job(vecs[0], 1'b0);
    wait_round(4'd5);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_idle("abort_now");
    check("abort_now_ct", ciphertext, 128'd0);
    step();
    check_idle("abort_clk");
    rst_n = 1'b1;
    drive_job(vecs[1], 1'b0);
    wait_valid();
    step();
    check_idle("abort_rerun");

    // Back-to-back with in_valid held: second accept 2 edges after out_valid rises.
    drive_job(vecs[2], 1'b1);
    plaintext = vecs[3].pt;
    key       = vecs[3].key;
    sb.push_back(vecs[3].ct);
    wait_valid();
    step();
    check("b2b_gap_out_valid", 128'(out_valid), 128'd0);
    check("b2b_gap_in_ready",  128'(in_ready),  128'd1);
    step();
    in_valid = 1'b0;
    check("b2b_acc_busy",  128'(busy),  128'd1);
    check("b2b_acc_round", 128'(round), 128'd1);
    wait_valid();
    step();
    check_idle("b2b_done");

    step();
    check("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
